// File: rtl/decoder_pkg.sv
// decoder_pkg: shared select-width default and output-width derivation for the decoder family
package decoder_pkg;
    localparam int SEL_W_DEF = 3;
    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction
endpackage

// File: rtl/decoder_core.sv
// decoder_core: combinational active-high one-hot decode of a, gated by en
module decoder_core
    import decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic [SEL_W-1:0] a,
    input  logic             en,
    output logic [OUT_W-1:0] y_comb
);
    always_comb y_comb = en ? OUT_W'(1) << a : '0;
endmodule

// File: rtl/decoder3_8.sv
// decoder3_8: registered one-hot decoder with selectable output polarity and a valid flag
module decoder3_8
    import decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W = out_w(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] a,
    output logic [OUT_W-1:0] y,
    output logic             y_vld
);
    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $error("decoder3_8: SEL_W=%0d outside 1..6", SEL_W);
    end
    localparam logic [OUT_W-1:0] POL = {OUT_W{ACTIVE_LOW}};
    logic [OUT_W-1:0] y_comb, y_d, y_q;
    logic             y_vld_d, y_vld_q;
    decoder_core #(.SEL_W(SEL_W)) u_core (
        .a      (a),
        .en     (en),
        .y_comb (y_comb)
    );
    always_comb begin
        y_d     = y_comb ^ POL;
        y_vld_d = en;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= POL;
            y_vld_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end
    assign y     = y_q;
    assign y_vld = y_vld_q;
    // active lines are exactly one-hot while valid, and all idle otherwise
    a_onehot_iff_vld: assert property (@(posedge clk) disable iff (rst)
        $onehot(y_q ^ POL) == y_vld_q);
endmodule

// File: tb/tb_decoder3_8.sv
// tb_decoder3_8: random and directed stimulus against a behavioural decode model, both polarities
module tb_decoder3_8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] a = 3'd5;
    logic [7:0] y, y_n;
    logic       y_vld, y_vld_n;
    logic [7:0] exp_y = 8'h00;
    logic       exp_vld = 1'b0;
    logic       model_ok = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] lit [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    decoder3_8 #(.SEL_W(3), .ACTIVE_LOW(1'b0)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .y     (y),
        .y_vld (y_vld)
    );

    decoder3_8 #(.SEL_W(3), .ACTIVE_LOW(1'b1)) dut_n (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .y     (y_n),
        .y_vld (y_vld_n)
    );

    // the model: line number a is lit when enabled, nothing otherwise; reset wins
    always @(posedge clk) begin
        exp_y    <= (rst || !en) ? 8'h00 : 8'(2 ** int'(a));
        exp_vld  <= !rst && en;
        model_ok <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (y !== exp_y || y_vld !== exp_vld || y_n !== ~exp_y || y_vld_n !== exp_vld) begin
                errors++;
                $display("FAIL model t=%0t y=%h vld=%b y_n=%h vld_n=%b want y=%h vld=%b y_n=%h",
                         $time, y, y_vld, y_n, y_vld_n, exp_y, exp_vld, ~exp_y);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [2:0] aa);
        rst = r;
        en  = e;
        a   = aa;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got_y, input logic got_v,
                       input logic [7:0] want_y, input logic want_v);
        checks++;
        if (got_y !== want_y || got_v !== want_v) begin
            errors++;
            $display("FAIL %s got y=%h vld=%b want y=%h vld=%b", name, got_y, got_v, want_y, want_v);
        end
    endtask

    initial begin
        cyc(1, 1, 3'd5);
        chk("reset1", y, y_vld, 8'h00, 1'b0);
        chk("reset1_n", y_n, y_vld_n, 8'hFF, 1'b0);
        cyc(1, 1, 3'd5);
        chk("reset2", y, y_vld, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 3'(i));
            chk($sformatf("sweep%0d", i), y, y_vld, lit[i], 1'b1);
        end
        cyc(0, 1, 3'd3);
        chk("gate_on1", y, y_vld, 8'h08, 1'b1);
        cyc(0, 0, 3'd3);
        chk("gate_off", y, y_vld, 8'h00, 1'b0);
        cyc(0, 1, 3'd3);
        chk("gate_on2", y, y_vld, 8'h08, 1'b1);
        cyc(0, 1, 3'd6);
        chk("pre_rst", y, y_vld, 8'h40, 1'b1);
        cyc(1, 1, 3'd6);
        chk("mid_rst", y, y_vld, 8'h00, 1'b0);
        chk("mid_rst_n", y_n, y_vld_n, 8'hFF, 1'b0);
        cyc(0, 1, 3'd6);
        chk("post_rst", y, y_vld, 8'h40, 1'b1);
        cyc(0, 1, 3'd2);
        chk("active_low", y_n, y_vld_n, 8'hFB, 1'b1);
        cyc(0, 0, 3'd2);
        chk("active_low_idle", y_n, y_vld_n, 8'hFF, 1'b0);
        // mid-cycle wiggles on a must never reach y before the next edge
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 3'($urandom));
            #2 a = 3'($urandom);
        end
        cyc(0, 0, 3'd0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder3_8.md
DECODER3_8 -- requirements
Module: decoder3_8

Interface
REQ-001 Parameter SEL_W, default 3: select width; SHALL be legal in the range 1..6.
REQ-002 Parameter OUT_W, default 2**SEL_W (8): output width; SHALL be derived and not overridable.
REQ-003 Parameter ACTIVE_LOW, default 0: when 1, output y is inverted (selected line 0, others 1).
REQ-004 Port: clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst, input, 1, reset, synchronous and active-high.
REQ-006 Port: en, input, 1, decode enable; en=0 forces all lines inactive.
REQ-007 Port: a, input, SEL_W, binary select code.
REQ-008 Port: y, output, OUT_W, registered one-hot decode of a.
REQ-009 Port: y_vld, output, 1, high when y holds a decode of an enabled sample.

Function
REQ-010 The block SHALL compute the next value of y as follows:
- en=1: bit a set, all other bits clear.
- en=0: all bits clear.
REQ-011 Output mapping SHALL be bit-exact to the rising edge (ACTIVE_LOW=0):
- a=000 -> y=00000001; a=001 -> 00000010; a=010 -> 00000100; a=011 -> 00001000.
- a=100 -> 00010000; a=101 -> 00100000; a=110 -> 01000000; a=111 -> 10000000.
REQ-012 Latency SHALL be exactly one clk cycle: a/en sampled at edge k appear on y and y_vld after edge k.
REQ-013 y_vld SHALL equal the value of en registered on the same edge as y.
REQ-014 With ACTIVE_LOW=1, y SHALL be the bitwise inverse of the ACTIVE_LOW=0 value, including the idle and reset values.
REQ-015 Exactly one bit of y SHALL be active whenever y_vld=1; no bits SHALL be active whenever y_vld=0.
REQ-016 a containing X/Z is not a legal stimulus; the block SHALL NOT be required to produce a defined y for it.
REQ-017 A change of a between edges SHALL NOT affect y until the next edge; there is no combinational path from a or en to y.
REQ-018 Back-to-back changes of a on consecutive edges SHALL each be reflected in y one cycle later, with no dropped or merged codes.

Reset
REQ-019 While rst=1 at a rising edge, y SHALL load the inactive pattern (all 0, or all 1 if ACTIVE_LOW) and y_vld SHALL load 0.
REQ-020 rst SHALL take priority over en and a.
REQ-021 On the first edge after rst deasserts, the block SHALL sample a and en normally; the first valid output appears one cycle later.
REQ-022 Reset asserted mid-stream SHALL discard the pending decode; no output of the pre-reset code SHALL follow.

Structure
REQ-023 A shared package decoder_pkg SHALL hold the default SEL_W and a function computing OUT_W from SEL_W.
REQ-024 The combinational one-hot logic SHALL be a sub-module decoder_core with ports a, en and y_comb; decoder3_8 SHALL add only the polarity stage and output registers.
REQ-025 Parameter legality (SEL_W range) SHALL be checked at elaboration, failing the build when out of range.

Verification
REQ-026 Reset: rst=1 for 2 cycles with a=101 and en=1 -> y=00000000, y_vld=0 throughout.
REQ-027 Exhaustive sweep: en=1, a=000..111 on consecutive cycles -> y follows REQ-011 one cycle later, y_vld=1.
REQ-028 Enable gating: a=011, en toggles 1,0,1 -> y=00001000, 00000000, 00001000 and y_vld=1, 0, 1, each lagging one cycle.
REQ-029 Mid-stream reset: a=110, en=1, rst pulsed for one cycle -> y=00000000 and y_vld=0 on that edge, then 01000000 one cycle after rst drops.
REQ-030 ACTIVE_LOW=1 build: a=010, en=1 -> y=11111011; idle/reset -> y=11111111.
REQ-031 Assertion bound to every cycle: $onehot(y_active) iff y_vld, where y_active = y XOR {OUT_W{ACTIVE_LOW}}.
